// File: rtl/regfile_responder.sv
// 16 x 32 register file behind a request/response valid-ready pair.
// Each accepted read-pair or write yields one registered response; counters saturate.
module regfile_responder #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_ra,
   input  logic [ADDR_W-1:0] req_rb,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_a,
   output logic [DATA_W-1:0] rsp_b,
   output logic [CNT_W-1:0]  rd_count,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int NREGS = 2**ADDR_W;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   regs_q [NREGS];
   logic                rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0]   rsp_a_q, rsp_a_d;
   logic [DATA_W-1:0]   rsp_b_q, rsp_b_d;
   logic [CNT_W-1:0]    rd_count_q, rd_count_d;
   logic [CNT_W-1:0]    wr_count_q, wr_count_d;

   logic                accept;
   logic                wr_drop;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W-1:0]   rd_a;
   logic [DATA_W-1:0]   rd_b;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign req_ready = rst_n && ((state_q == EMPTY) || rsp_ready);
   assign accept    = req_valid && req_ready;

   // Register 0 is hardwired to zero when ZERO_REG is set: reads mask it, writes drop.
   assign wr_drop = (ZERO_REG != 0) && (req_ra == '0);
   assign wdata   = wr_drop ? '0 : req_data;
   assign rd_a    = ((ZERO_REG != 0) && (req_ra == '0)) ? '0 : regs_q[req_ra];
   assign rd_b    = ((ZERO_REG != 0) && (req_rb == '0)) ? '0 : regs_q[req_rb];

   always_comb begin
      state_d     = state_q;
      rsp_write_d = rsp_write_q;
      rsp_a_d     = rsp_a_q;
      rsp_b_d     = rsp_b_q;
      rd_count_d  = rd_count_q;
      wr_count_d  = wr_count_q;
      if (accept) begin
         state_d     = FULL;
         rsp_write_d = req_write;
         if (req_write) begin
            // Port B reports post-write state, so a same-index read sees the new data.
            rsp_a_d    = wdata;
            rsp_b_d    = (req_rb == req_ra) ? wdata : rd_b;
            wr_count_d = sat_inc(wr_count_q);
         end else begin
            rsp_a_d    = rd_a;
            rsp_b_d    = rd_b;
            rd_count_d = sat_inc(rd_count_q);
         end
      end else if (rsp_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         rsp_write_q <= 1'b0;
         rsp_a_q     <= '0;
         rsp_b_q     <= '0;
         rd_count_q  <= '0;
         wr_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         rsp_write_q <= rsp_write_d;
         rsp_a_q     <= rsp_a_d;
         rsp_b_q     <= rsp_b_d;
         rd_count_q  <= rd_count_d;
         wr_count_q  <= wr_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (accept && req_write && !wr_drop) begin
         regs_q[req_ra] <= req_data;
      end
   end

   assign rsp_valid = (state_q == FULL);
   assign rsp_write = rsp_write_q;
   assign rsp_a     = rsp_a_q;
   assign rsp_b     = rsp_b_q;
   assign rd_count  = rd_count_q;
   assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_regfile_responder.sv
// Scoreboard bench for regfile_responder: directed scenarios plus randomized traffic
// with random response backpressure, checked against an array-based register model.
module tb_regfile_responder;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready, req_write;
   logic [ADDR_W-1:0] req_ra, req_rb;
   logic [DATA_W-1:0] req_data;
   logic              rsp_valid, rsp_ready, rsp_write;
   logic [DATA_W-1:0] rsp_a, rsp_b;
   logic [CNT_W-1:0]  rd_count, wr_count;

   regfile_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_ra(req_ra), .req_rb(req_rb), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_a(rsp_a), .rsp_b(rsp_b), .rd_count(rd_count), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] b;
      int          rc;
      int          wc;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mem [16];
   int          rd_m, wr_m;
   int          checks = 0;
   int          failures = 0;
   bit          bp_mode = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      rd_m = 0;
      wr_m = 0;
      sbq.delete();
   endtask

   // Reference: a write updates the array (index 0 never changes), then both ports
   // read the array as it stands after that update.
   task automatic model_accept(input logic w, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [31:0] d);
      exp_t e;
      if (w) begin
         if (ra != 4'd0) mem[ra] = d;
         if (wr_m < CMAX) wr_m++;
      end else begin
         if (rd_m < CMAX) rd_m++;
      end
      e.w  = w;
      e.a  = mem[ra];
      e.b  = mem[rb];
      e.rc = rd_m;
      e.wc = wr_m;
      sbq.push_back(e);
   endtask

   // Inputs change at posedge+2; all sampling happens at negedge.
   task automatic send(input logic w, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [31:0] d, output int waits);
      req_valid = 1'b1;
      req_write = w;
      req_ra    = ra;
      req_rb    = rb;
      req_data  = d;
      waits     = 0;
      forever begin
         @(negedge clk);
         if (req_ready) begin
            model_accept(w, ra, rb, d);
            break;
         end
         waits++;
         if (waits >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_accept required=accept_within_200");
            break;
         end
         @(posedge clk); #2;
      end
      @(posedge clk); #2;
      req_valid = 1'b0;
      req_write = 1'b0;
   endtask

   // A write request is presented throughout reset; it must never commit.
   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_ra    = 4'd6;
      req_rb    = 4'd6;
      req_data  = 32'h0BAD_F00D;
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      model_reset();
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_write", 64'(rsp_write), 64'd0);
      chk("rst_rsp_a", 64'(rsp_a), 64'd0);
      chk("rst_rsp_b", 64'(rsp_b), 64'd0);
      chk("rst_rd_count", 64'(rd_count), 64'd0);
      chk("rst_wr_count", 64'(wr_count), 64'd0);
      #1;
      rst_n     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rsp_ready = 1'b1;
      while (sbq.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #2;
      chk("drain_left", 64'(sbq.size()), 64'd0);
   endtask

   // Monitor: pops on each response handshake; checks stability under backpressure.
   bit          stall_prev = 0;
   logic        prev_w;
   logic [31:0] prev_a, prev_b;
   exp_t        me;

   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_prev) begin
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_write", 64'(rsp_write), 64'(prev_w));
            chk("hold_a", 64'(rsp_a), 64'(prev_a));
            chk("hold_b", 64'(rsp_b), 64'(prev_b));
         end
         if (rsp_valid && !rsp_ready)
            chk("bp_no_ready", 64'(req_ready), 64'd0);
         if (rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp actual=rsp_valid required=no_response");
            end else begin
               me = sbq.pop_front();
               chk("rsp_write", 64'(rsp_write), 64'(me.w));
               chk("rsp_a", 64'(rsp_a), 64'(me.a));
               chk("rsp_b", 64'(rsp_b), 64'(me.b));
               chk("rd_count", 64'(rd_count), 64'(me.rc));
               chk("wr_count", 64'(wr_count), 64'(me.wc));
            end
         end
         stall_prev = rsp_valid && !rsp_ready;
         prev_w     = rsp_write;
         prev_a     = rsp_a;
         prev_b     = rsp_b;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      forever begin
         @(posedge clk); #2;
         if (bp_mode) rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   int w0, w1;

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_ra    = '0;
      req_rb    = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      model_reset();
      @(posedge clk); #2;
      do_reset();

      // Basic write then same-index read pair.
      send(1'b1, 4'd1, 4'd0, 32'd42, w0);
      send(1'b0, 4'd1, 4'd1, 32'd0, w0);
      drain();

      // Back-to-back write then read with no bubble.
      send(1'b1, 4'd3, 4'd0, 32'hDEADBEEF, w0);
      send(1'b0, 4'd3, 4'd2, 32'd0, w1);
      chk("b2b_wait_wr", 64'(w0), 64'd0);
      chk("b2b_wait_rd", 64'(w1), 64'd0);
      drain();

      // Backpressure: hold 3 cycles, next request accepted on release edge.
      send(1'b0, 4'd1, 4'd1, 32'd0, w0);
      rsp_ready = 1'b0;
      fork
         begin
            repeat (3) begin
               @(negedge clk);
               chk("bp3_req_ready", 64'(req_ready), 64'd0);
               chk("bp3_rsp_a", 64'(rsp_a), 64'd42);
            end
            @(posedge clk); #2;
            rsp_ready = 1'b1;
         end
         send(1'b0, 4'd2, 4'd1, 32'd0, w1);
      join
      chk("bp_wait", 64'(w1), 64'd3);
      drain();

      // Zero register.
      do_reset();
      send(1'b1, 4'd0, 4'd0, 32'd7, w0);
      send(1'b0, 4'd0, 4'd0, 32'd0, w0);
      drain();
      chk("zero_wr_count", 64'(wr_count), 64'd1);

      // Reset while a response is held.
      send(1'b1, 4'd5, 4'd5, 32'd9, w0);
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("held_valid", 64'(rsp_valid), 64'd1);
      chk("held_a", 64'(rsp_a), 64'd9);
      @(posedge clk); #2;
      do_reset();
      rsp_ready = 1'b1;
      send(1'b0, 4'd5, 4'd6, 32'd0, w0);
      drain();

      // Counter saturation.
      do_reset();
      for (int i = 0; i < 20; i++)
         send(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 32'd0, w0);
      drain();
      chk("sat_rd_count", 64'(rd_count), 64'(CMAX));
      chk("sat_wr_count", 64'(wr_count), 64'd0);

      // Random traffic with random backpressure.
      do_reset();
      bp_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), $urandom, w0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #2;
         end
      end
      bp_mode   = 1'b0;
      rsp_ready = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
